gray_ptr_sync_w2r: RTL and testbench
====================================

GRAY_PTR_SYNC_W2R -- requirements
Module: gray_ptr_sync_w2r

Interface
REQ-001 Parameter ADDRESS_BITS, default 4, FIFO address width; pointers are ADDRESS_BITS+1 bits (wrap bit included).
REQ-002 Parameter SYNC_STAGES, default 2, number of synchroniser flops; legal range 2..4.
REQ-003 rclk  input  1  read-domain clock; all state updates on posedge.
REQ-004 rrst  input  1  asynchronous, active-low reset.
REQ-005 wptr_gray  input  ADDRESS_BITS+1  write pointer, Gray-coded, launched from the write clock domain.
REQ-006 rptr_bin  input  ADDRESS_BITS+1  read pointer, binary, read-clock domain.
REQ-007 clr_err  input  1  synchronous clear of the sticky error flags.
REQ-008 rq_wptr_gray  output  ADDRESS_BITS+1  synchronised write pointer, Gray.
REQ-009 rq_wptr_bin  output  ADDRESS_BITS+1  synchronised write pointer, binary.
REQ-010 r_fill  output  ADDRESS_BITS+1  occupancy seen by the read side.
REQ-011 r_empty  output  1  FIFO empty, read side.
REQ-012 sync_valid  output  1  synchroniser flushed; derived outputs trustworthy.
REQ-013 wptr_adv  output  1  synchronised write pointer moved this cycle.
REQ-014 gray_err  output  1  sticky: illegal multi-bit Gray step seen.
REQ-015 fill_err  output  1  sticky: occupancy exceeded 2^ADDRESS_BITS.

Function
REQ-016 Chain of SYNC_STAGES registers; stage 1 samples wptr_gray; rq_wptr_gray = last stage; latency exactly SYNC_STAGES rclk edges.
REQ-017 rq_wptr_bin is the combinational Gray-to-binary conversion of rq_wptr_gray (bit MSB copied, bit i = bit i+1 XOR gray bit i).
REQ-018 r_fill = (rq_wptr_bin - rptr_bin) modulo 2^(ADDRESS_BITS+1), combinational; correct across pointer wrap-around.
REQ-019 r_empty = 1 when r_fill == 0, combinational.
REQ-020 Register prev_gray loads rq_wptr_gray every rclk edge.
REQ-021 wptr_adv = sync_valid AND (rq_wptr_gray != prev_gray), combinational.
REQ-022 sync_valid: 3-bit counter from 0 after reset, increments per edge, saturates; sync_valid = 1 once count reaches SYNC_STAGES+1.
REQ-023 gray_err sets on an edge where sync_valid=1 and popcount(rq_wptr_gray XOR prev_gray) > 1.
REQ-024 fill_err sets on an edge where sync_valid=1 and r_fill > 2^ADDRESS_BITS.
REQ-025 clr_err=1 clears both sticky flags on the next edge; a set condition on the same edge wins over clear.
REQ-026 No combinational path from wptr_gray to any output.

Reset
REQ-027 rrst low SHALL immediately clear all sync stages, prev_gray, counter, gray_err, fill_err; hence rq_wptr_gray=0, rq_wptr_bin=0, r_fill=-rptr_bin mod 2^(ADDRESS_BITS+1), sync_valid=0, wptr_adv=0.
REQ-028 Reset asserted mid-operation SHALL behave identically to power-on reset; sync_valid re-qualifies after SYNC_STAGES+1 edges.
REQ-029 Reset deassertion is assumed synchronised to rclk externally; the block contains no reset synchroniser.

Structure
REQ-030 Shared package fifo_pkg holds gray2bin and bin2gray functions, SYNC_STAGES_MIN/MAX constants, and a ptr_t typedef parameterised by ADDRESS_BITS via function width.
REQ-031 One sub-module sync_chain (parameterised WIDTH, STAGES, async active-low reset) implements REQ-016; an elaboration-time check rejects SYNC_STAGES outside 2..4.

Verification
REQ-032 Reset, SYNC_STAGES=2, hold wptr_gray=0 -> sync_valid rises on 3rd edge; r_empty=1, r_fill=0, flags 0.
REQ-033 wptr_gray steps 0->1 (bin 1), rptr_bin=0 -> rq_wptr_gray=1 exactly 2 edges later, wptr_adv pulses 1 cycle, r_fill=1, r_empty=0.
REQ-034 Wrap: ADDRESS_BITS=4, wptr bin 31->0 (Gray 10000->00000), rptr_bin=30 -> r_fill goes 1 then 2; no gray_err.
REQ-035 Force wptr_gray 00000->00011 in one step -> gray_err=1 after sync latency+1; clr_err with no new fault clears it next edge.
REQ-036 wptr bin 17, rptr_bin 0 (r_fill=17 > 16) -> fill_err=1; clr_err on same edge as a repeat violation -> fill_err stays 1.
REQ-037 SYNC_STAGES=4, assert rrst mid-stream with r_fill=5 -> all outputs reset instantly; after release sync_valid returns on 5th edge.

Source files
------------

// File: rtl/gray_ptr_sync_w2r_pkg.sv
// fifo_pkg: shared FIFO pointer helpers.
// Contents:
//   SYNC_STAGES_MIN/MAX  legal synchroniser depth range
//   ADDRESS_BITS_MAX     widest supported FIFO address
//   ptr_t                pointer container, wide enough for any legal ADDRESS_BITS
//   ptr_width()          pointer width (address bits plus wrap bit)
//   gray2bin/bin2gray    code conversions on a zero-extended ptr_t
// Zero-extending a narrower pointer into ptr_t leaves both conversions correct
// in the low bits, so callers simply truncate the result back to their width.
package fifo_pkg;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int ADDRESS_BITS_MAX = 15;
  typedef logic [ADDRESS_BITS_MAX:0] ptr_t;
  function automatic int ptr_width(int address_bits);
    return address_bits + 1;
  endfunction
  function automatic ptr_t gray2bin(ptr_t g);
    ptr_t b;
    b[ADDRESS_BITS_MAX] = g[ADDRESS_BITS_MAX];
    for (int i = ADDRESS_BITS_MAX - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic ptr_t bin2gray(ptr_t b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/gray_ptr_sync_w2r_if.sv
// gray_ptr_sync_w2r_if: read-side bundle of the write-pointer synchroniser.
// Ports (slave = synchroniser side):
//   wptr_gray     in   write pointer, Gray, from the write clock domain
//   rptr_bin      in   read pointer, binary
//   clr_err       in   synchronous clear of the sticky error flags
//   rq_wptr_gray  out  synchronised write pointer, Gray
//   rq_wptr_bin   out  synchronised write pointer, binary
//   r_fill        out  occupancy seen by the read side
//   r_empty       out  FIFO empty
//   sync_valid    out  synchroniser flushed since reset
//   wptr_adv      out  synchronised pointer moved this cycle
//   gray_err      out  sticky illegal Gray step
//   fill_err      out  sticky occupancy overflow
interface gray_ptr_sync_w2r_if #(parameter int ADDRESS_BITS = 4);
  logic [ADDRESS_BITS:0] wptr_gray;
  logic [ADDRESS_BITS:0] rptr_bin;
  logic clr_err;
  logic [ADDRESS_BITS:0] rq_wptr_gray;
  logic [ADDRESS_BITS:0] rq_wptr_bin;
  logic [ADDRESS_BITS:0] r_fill;
  logic r_empty;
  logic sync_valid;
  logic wptr_adv;
  logic gray_err;
  logic fill_err;
  modport slave (
    input wptr_gray, rptr_bin, clr_err,
    output rq_wptr_gray, rq_wptr_bin, r_fill, r_empty, sync_valid, wptr_adv, gray_err, fill_err
  );
  modport master (
    output wptr_gray, rptr_bin, clr_err,
    input rq_wptr_gray, rq_wptr_bin, r_fill, r_empty, sync_valid, wptr_adv, gray_err, fill_err
  );
endinterface

// File: rtl/gray_ptr_sync_w2r_sync_chain.sv
// sync_chain: multi-flop synchroniser with asynchronous active-low reset.
// Ports:
//   i_clk    destination clock
//   i_rst_n  asynchronous active-low reset
//   i_d      asynchronous input bus
//   o_q      input delayed by exactly STAGES i_clk edges
module sync_chain
  import fifo_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("sync_chain: STAGES=%0d outside %0d..%0d", STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  end
  logic [STAGES-1:0][WIDTH-1:0] r_s;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_s <= '0;
    else r_s <= {r_s[STAGES-2:0], i_d};
  assign o_q = r_s[STAGES-1];
endmodule

// File: rtl/gray_ptr_sync_w2r.sv
// gray_ptr_sync_w2r: brings a Gray write pointer into the read clock domain.
// Ports:
//   rclk  read-domain clock
//   rrst  asynchronous active-low reset
//   bus   gray_ptr_sync_w2r_if.slave (pointers in; synchronised pointer,
//         occupancy, empty, qualification and sticky error flags out)
// Only the synchroniser output feeds the derived outputs, so nothing
// downstream sees the asynchronous write pointer directly.
module gray_ptr_sync_w2r
  import fifo_pkg::*;
#(
  parameter int ADDRESS_BITS = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic rclk,
  input logic rrst,
  gray_ptr_sync_w2r_if.slave bus
);
  localparam int W = ptr_width(ADDRESS_BITS);
  localparam logic [W-1:0] DEPTH = W'(1) << ADDRESS_BITS;
  logic [W-1:0] w_q;
  logic [W-1:0] w_bin;
  logic [W-1:0] w_fill;
  logic [W-1:0] r_prev;
  logic [2:0] r_cnt;
  logic w_valid;
  logic r_gray_err;
  logic r_fill_err;
  sync_chain #(.WIDTH(W), .STAGES(SYNC_STAGES)) u_sync (
    .i_clk(rclk),
    .i_rst_n(rrst),
    .i_d(bus.wptr_gray),
    .o_q(w_q)
  );
  assign w_bin = W'(gray2bin(ptr_t'(w_q)));
  assign w_fill = w_bin - bus.rptr_bin;
  // The extra edge beyond the chain depth guarantees r_prev also holds a
  // post-reset synchronised value before any step is judged.
  assign w_valid = r_cnt >= 3'(SYNC_STAGES + 1);
  always_ff @(posedge rclk or negedge rrst)
    if (!rrst) begin
      r_prev <= '0;
      r_cnt <= '0;
      r_gray_err <= 1'b0;
      r_fill_err <= 1'b0;
    end else begin
      r_prev <= w_q;
      r_cnt <= (r_cnt == 3'd7) ? r_cnt : r_cnt + 3'd1;
      r_gray_err <= (w_valid && $countones(w_q ^ r_prev) > 1) || (r_gray_err && !bus.clr_err);
      r_fill_err <= (w_valid && w_fill > DEPTH) || (r_fill_err && !bus.clr_err);
    end
  assign bus.rq_wptr_gray = w_q;
  assign bus.rq_wptr_bin = w_bin;
  assign bus.r_fill = w_fill;
  assign bus.r_empty = w_fill == '0;
  assign bus.sync_valid = w_valid;
  assign bus.wptr_adv = w_valid && (w_q != r_prev);
  assign bus.gray_err = r_gray_err;
  assign bus.fill_err = r_fill_err;
endmodule

// File: tb/tb_gray_ptr_sync_w2r.sv
// tb_gray_ptr_sync_w2r: directed and random checks of two synchroniser
// depths (2 and 4 stages) driven in parallel against a history-based model.
module tb_gray_ptr_sync_w2r;
  logic rclk;
  logic rrst;
  logic [4:0] wptr;
  logic [4:0] rptr;
  logic clr;
  int vectors;
  int miscompares;
  int wh[$];
  int e;
  int gerr[2];
  int ferr[2];
  int wb;

  gray_ptr_sync_w2r_if #(.ADDRESS_BITS(4)) if2 ();
  gray_ptr_sync_w2r_if #(.ADDRESS_BITS(4)) if4 ();
  assign if2.wptr_gray = wptr;
  assign if2.rptr_bin = rptr;
  assign if2.clr_err = clr;
  assign if4.wptr_gray = wptr;
  assign if4.rptr_bin = rptr;
  assign if4.clr_err = clr;

  gray_ptr_sync_w2r #(.ADDRESS_BITS(4), .SYNC_STAGES(2)) u_dut2 (.rclk(rclk), .rrst(rrst), .bus(if2.slave));
  gray_ptr_sync_w2r #(.ADDRESS_BITS(4), .SYNC_STAGES(4)) u_dut4 (.rclk(rclk), .rrst(rrst), .bus(if4.slave));

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic logic [4:0] gray(int b);
    return 5'((b ^ (b >> 1)) & 31);
  endfunction

  function automatic int g2b(int g);
    for (int b = 0; b < 32; b++) if ((b ^ (b >> 1)) == g) return b;
    return -1;
  endfunction

  function automatic int popc(int x);
    int c = 0;
    for (int i = 0; i < 32; i++) c += (x >> i) & 1;
    return c;
  endfunction

  // Synchronised pointer seen after n edges since reset: the sample taken s edges earlier.
  function automatic int rq_at(int s, int n);
    return (n >= s) ? wh[n-s] : 0;
  endfunction

  function automatic int prev_at(int s, int n);
    return (n >= 1) ? rq_at(s, n - 1) : 0;
  endfunction

  function automatic int fill_at(int s, int n);
    return (g2b(rq_at(s, n)) - int'(rptr)) & 31;
  endfunction

  task automatic model_reset();
    wh.delete();
    e = 0;
    gerr = '{0, 0};
    ferr = '{0, 0};
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int s = k ? 4 : 2;
      bit v = e >= s + 1;
      if (v && popc(rq_at(s, e) ^ prev_at(s, e)) > 1) gerr[k] = 1;
      else if (clr) gerr[k] = 0;
      if (v && fill_at(s, e) > 16) ferr[k] = 1;
      else if (clr) ferr[k] = 0;
    end
    wh.push_back(int'(wptr));
    e++;
  endtask

  task automatic check(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s[S=%0d] observed %0d expected %0d", tag, k ? 4 : 2, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int s = k ? 4 : 2;
      int rq = rq_at(s, e);
      int f = fill_at(s, e);
      bit v = e >= s + 1;
      check("rq_wptr_gray", k, k ? if4.rq_wptr_gray : if2.rq_wptr_gray, rq);
      check("rq_wptr_bin", k, k ? if4.rq_wptr_bin : if2.rq_wptr_bin, g2b(rq));
      check("r_fill", k, k ? if4.r_fill : if2.r_fill, f);
      check("r_empty", k, k ? if4.r_empty : if2.r_empty, f == 0);
      check("sync_valid", k, k ? if4.sync_valid : if2.sync_valid, v);
      check("wptr_adv", k, k ? if4.wptr_adv : if2.wptr_adv, v && rq != prev_at(s, e));
      check("gray_err", k, k ? if4.gray_err : if2.gray_err, gerr[k]);
      check("fill_err", k, k ? if4.fill_err : if2.fill_err, ferr[k]);
    end
  endtask

  task automatic step();
    @(posedge rclk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic mid_reset();
    #2 rrst = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge rclk) rrst = 1'b1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rrst = 1'b0;
    wptr = '0;
    rptr = '0;
    clr = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge rclk) rrst = 1'b1;
    repeat (2) step();
    check("valid_before_edge3", 0, if2.sync_valid, 0);
    step();
    check("valid_at_edge3", 0, if2.sync_valid, 1);
    check("empty_idle", 0, if2.r_empty, 1);
    repeat (3) step();
    wptr = gray(1);
    step();
    check("one_edge_latency", 0, if2.rq_wptr_gray, 0);
    step();
    check("two_edge_latency", 0, if2.rq_wptr_gray, 1);
    check("adv_pulse", 0, if2.wptr_adv, 1);
    step();
    check("adv_single", 0, if2.wptr_adv, 0);
    repeat (3) step();
    for (int b = 2; b < 32; b++) begin
      wptr = gray(b);
      rptr = 5'(b - 1);
      step();
    end
    rptr = 5'd30;
    repeat (5) step();
    check("wrap_fill_before", 1, if4.r_fill, 1);
    wptr = gray(0);
    repeat (6) step();
    check("wrap_fill_after", 0, if2.r_fill, 2);
    check("wrap_no_gray_err", 1, if4.gray_err, 0);
    wptr = 5'b00011;
    repeat (5) step();
    check("gray_err_set", 1, if4.gray_err, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("gray_err_clr", 1, if4.gray_err, 0);
    rptr = 5'd0;
    wptr = gray(17);
    repeat (6) step();
    check("fill_err_set", 0, if2.fill_err, 1);
    clr = 1'b1;
    step();
    check("fill_err_set_wins", 0, if2.fill_err, 1);
    rptr = 5'd17;
    step();
    clr = 1'b0;
    check("fill_err_clr", 1, if4.fill_err, 0);
    wptr = gray(22);
    repeat (6) step();
    check("pre_reset_fill", 1, if4.r_fill, 5);
    mid_reset();
    check("reset_valid", 1, if4.sync_valid, 0);
    check("reset_rq", 1, if4.rq_wptr_gray, 0);
    repeat (4) step();
    check("valid_before_edge5", 1, if4.sync_valid, 0);
    step();
    check("valid_at_edge5", 1, if4.sync_valid, 1);
    wb = 22;
    for (int i = 0; i < 400; i++) begin
      int r = int'($urandom_range(0, 99));
      if (r < 60) wb = (wb + 1) & 31;
      else if (r < 66) wb = int'($urandom_range(0, 31));
      wptr = gray(wb);
      rptr = 5'((wb - int'($urandom_range(0, 18))) & 31);
      clr = ($urandom_range(0, 7) == 0);
      step();
      if ($urandom_range(0, 59) == 0) mid_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
